ksa_shuffle: RTL and testbench

KSA_SHUFFLE -- requirements
Module: ksa_shuffle

---
 rtl/ksa_pkg.sv | 22 ++
 rtl/ksa_key_sel.sv | 32 +++
 rtl/ksa_shuffle.sv | 114 +++++++++++
 tb/tb_ksa_shuffle.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling (KSA) shuffle engine.
package ksa_pkg;

    localparam int KEY_BYTES   = 3;
    localparam int MEM_DEPTH   = 256;
    localparam int ITER_CYCLES = 6;

    localparam logic [7:0] LAST_IDX     = 8'(MEM_DEPTH - 1);
    localparam logic [1:0] LAST_KEY_IDX = 2'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LAT_I,
        RD_J,
        LAT_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

endpackage

// File: rtl/ksa_key_sel.sv
// Key byte selector: mod-3 index counter walking byte0, byte1, byte2 of the latched key.
module ksa_key_sel
    import ksa_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        advance,
    input  logic [23:0] key,
    output logic [7:0]  key_byte
);

    logic [1:0] key_idx;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            key_idx <= 2'd0;
        end else if (advance) begin
            key_idx <= (key_idx == LAST_KEY_IDX) ? 2'd0 : key_idx + 2'd1;
        end
    end

    always_comb begin
        case (key_idx)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    end

endmodule

// File: rtl/ksa_shuffle.sv
// RC4 KSA shuffle over an external synchronous-read 256-byte S memory, 6 cycles per iteration.
module ksa_shuffle
    import ksa_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] secret_key,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    output logic        s_wren,
    input  logic [7:0]  s_q,
    output logic        SHUFFLE_FINISHED
);

    state_t      state;
    state_t      state_next;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  si;
    logic [7:0]  sj;
    logic [23:0] key_q;
    logic [7:0]  key_byte;
    logic        start_accept;
    logic        advance;

    assign start_accept = start && (state == IDLE || state == DONE);
    assign advance      = (state == WR_J) && (i != LAST_IDX);

    ksa_key_sel u_key_sel (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (start_accept),
        .advance  (advance),
        .key      (key_q),
        .key_byte (key_byte)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD_I;
            RD_I:    state_next = LAT_I;
            LAT_I:   state_next = RD_J;
            RD_J:    state_next = LAT_J;
            LAT_J:   state_next = WR_I;
            WR_I:    state_next = WR_J;
            WR_J:    state_next = (i == LAST_IDX) ? DONE : RD_I;
            DONE:    if (start) state_next = RD_I;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            key_q <= 24'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_q <= secret_key;
                        i     <= 8'd0;
                        j     <= 8'd0;
                    end
                end
                LAT_I: begin
                    si <= s_q;
                    j  <= j + s_q + key_byte;
                end
                LAT_J: sj <= s_q;
                WR_J:  if (i != LAST_IDX) i <= i + 8'd1;
                default: ;
            endcase
        end
    end

    // With i == j both writes carry the same byte, so S is left unchanged.
    always_comb begin
        s_address        = 8'd0;
        s_data           = 8'd0;
        s_wren           = 1'b0;
        SHUFFLE_FINISHED = 1'b0;
        case (state)
            RD_I: s_address = i;
            RD_J: s_address = j;
            WR_I: begin
                s_address = i;
                s_data    = sj;
                s_wren    = 1'b1;
            end
            WR_J: begin
                s_address = j;
                s_data    = si;
                s_wren    = 1'b1;
            end
            DONE: SHUFFLE_FINISHED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Bench for ksa_shuffle: S-memory model, software RC4 KSA scoreboard of expected writes.
module tb_ksa_shuffle;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key = 24'd0;
    logic [7:0]  s_address;
    logic [7:0]  s_data;
    logic        s_wren;
    logic [7:0]  s_q;
    logic        SHUFFLE_FINISHED;

    logic [7:0]  mem [256];
    logic [7:0]  model_mem [256];
    logic        mem_init_req = 1'b0;

    wr_t exp_q [$];
    wr_t wr_log [8];
    int  wr_count;
    int  fin_edge;
    int  wren_total;
    bit  aborted;

    int vectors = 0;
    int miscompares = 0;

    ksa_shuffle dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .secret_key       (secret_key),
        .s_address        (s_address),
        .s_data           (s_data),
        .s_wren           (s_wren),
        .s_q              (s_q),
        .SHUFFLE_FINISHED (SHUFFLE_FINISHED)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        if (mem_init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (s_wren) begin
            mem[s_address] <= s_data;
        end
        s_q <= mem[s_address];
    end

    task automatic init_mem();
        mem_init_req = 1'b1;
        @(negedge clk);
        mem_init_req = 1'b0;
        for (int k = 0; k < 256; k++) model_mem[k] = 8'(k);
    endtask

    // Software RC4 KSA; queues the write pair each iteration should produce.
    task automatic model_ksa(input logic [23:0] key);
        logic [7:0] j;
        logic [7:0] kb;
        logic [7:0] t;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = key[23:16];
                1:       kb = key[15:8];
                default: kb = key[7:0];
            endcase
            j = j + model_mem[i] + kb;
            exp_q.push_back({8'(i), model_mem[j]});
            exp_q.push_back({j, model_mem[i]});
            t = model_mem[i];
            model_mem[i] = model_mem[j];
            model_mem[j] = t;
        end
    endtask

    task automatic run_shuffle(input logic [23:0] key, input bit disturb, input int reset_at);
        wr_t got;
        wr_t exp;
        exp_q.delete();
        model_ksa(key);
        secret_key = key;
        start      = 1'b1;
        wr_count   = 0;
        fin_edge   = -1;
        wren_total = 0;
        aborted    = 1'b0;
        for (int n = 0; n <= 3000; n++) begin
            @(negedge clk);
            start = disturb && (n == 62 || n == 124);
            if (disturb && n == 30) secret_key = ~key;
            if (SHUFFLE_FINISHED) begin
                fin_edge = n;
                break;
            end
            vectors++;
            if (s_wren) begin
                wren_total++;
                got = {s_address, s_data};
                if (wr_count < 8) wr_log[wr_count] = got;
                wr_count++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", got.addr, got.data);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL write_%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                                 wr_count - 1, got.addr, got.data, exp.addr, exp.data);
                    end
                end
            end else if (s_data !== 8'd0) begin
                miscompares++;
                $display("FAIL idle_data: got %0d, required 0", s_data);
            end
            if (n == reset_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                vectors++;
                if ({s_wren, s_address, s_data, SHUFFLE_FINISHED} !== 18'd0) begin
                    miscompares++;
                    $display("FAIL reset_mid_write: got wren=%b addr=%0d data=%0d fin=%b, required all 0",
                             s_wren, s_address, s_data, SHUFFLE_FINISHED);
                end
                reset_n = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        secret_key = key;
        if (!aborted && fin_edge < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no SHUFFLE_FINISHED, required it at edge 1536");
        end
    endtask

    task automatic check_end(input string name);
        vectors++;
        if (fin_edge != 1536) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d, required 1536", name, fin_edge);
        end
        vectors++;
        if (wren_total != 512) begin
            miscompares++;
            $display("FAIL %s_wren_count: got %0d, required 512", name, wren_total);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_writes: got %0d left, required 0", name, exp_q.size());
        end
        for (int k = 0; k < 256; k++) begin
            vectors++;
            if (mem[k] !== model_mem[k]) begin
                miscompares++;
                $display("FAIL %s_mem[%0d]: got %0d, required %0d", name, k, mem[k], model_mem[k]);
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({SHUFFLE_FINISHED, s_wren, s_address} !== 10'b10_0000_0000) begin
            miscompares++;
            $display("FAIL %s_done_hold: got fin=%b wren=%b addr=%0d, required 1 0 0",
                     name, SHUFFLE_FINISHED, s_wren, s_address);
        end
    endtask

    task automatic check_log(input string name, input int idx, input logic [7:0] addr, input logic [7:0] data);
        vectors++;
        if (wr_log[idx] !== {addr, data}) begin
            miscompares++;
            $display("FAIL %s_log%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     name, idx, wr_log[idx].addr, wr_log[idx].data, addr, data);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_wren, s_address, s_data, SHUFFLE_FINISHED} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got wren=%b addr=%0d data=%0d fin=%b, required all 0",
                     s_wren, s_address, s_data, SHUFFLE_FINISHED);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({s_wren, s_address, SHUFFLE_FINISHED} !== 10'd0) begin
            miscompares++;
            $display("FAIL idle_outputs: got wren=%b addr=%0d fin=%b, required all 0",
                     s_wren, s_address, SHUFFLE_FINISHED);
        end
    endtask

    task automatic test_identity_key();
        init_mem();
        run_shuffle(24'h000000, 1'b0, -1);
        check_end("key0");
        check_log("key0", 0, 8'd0, 8'd0);
        check_log("key0", 1, 8'd0, 8'd0);
        check_log("key0", 2, 8'd1, 8'd1);
        check_log("key0", 3, 8'd1, 8'd1);
        check_log("key0", 4, 8'd2, 8'd3);
        check_log("key0", 5, 8'd3, 8'd2);
    endtask

    task automatic test_rc4_key();
        init_mem();
        run_shuffle(24'h000102, 1'b0, -1);
        check_end("rc4");
        check_log("rc4", 0, 8'd0, 8'd0);
        check_log("rc4", 1, 8'd0, 8'd0);
        check_log("rc4", 2, 8'd1, 8'd2);
        check_log("rc4", 3, 8'd2, 8'd1);
    endtask

    task automatic test_ignore_start();
        init_mem();
        run_shuffle(24'h5A3C81, 1'b1, -1);
        check_end("ignore");
    endtask

    task automatic test_reset_mid();
        init_mem();
        run_shuffle(24'h123456, 1'b0, 100 * 6 + 4);
        init_mem();
        run_shuffle(24'h123456, 1'b0, -1);
        check_end("after_reset");
        check_log("after_reset", 0, 8'd0, model_first_data(24'h123456));
    endtask

    // Expected first write data of a fresh run from identity memory: S[j] with j = key byte0.
    function automatic logic [7:0] model_first_data(input logic [23:0] key);
        logic [7:0] kb;
        kb = key[23:16];
        return kb;
    endfunction

    task automatic test_restart_done();
        run_shuffle(24'h0A0B0C, 1'b0, -1);
        check_end("restart");
    endtask

    initial begin
        test_reset();
        test_identity_key();
        test_rc4_key();
        test_ignore_start();
        test_reset_mid();
        test_restart_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
